// File: rtl/accum16_seq.sv
// Sequential 16-bit accumulator: sums a programmed number of stream samples
// through a ripple-carry sixteen_adder and presents the result on a held handshake.

module sixteen_adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [16:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign Sum[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[16];
endmodule

// Handshakes: a sample moves when in_valid && in_ready; the result moves when
// out_valid && out_ready. Ready/valid outputs come from registered state only.
module accum16_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_sum,
    output logic               out_carry,
    output logic [COUNT_W-1:0] out_count,
    output logic [1:0]         dbg_state_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [15:0]        sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] len_q, len_d;

    logic [15:0]        add_sum;
    logic               add_cout;
    logic [COUNT_W-1:0] count_inc;
    logic               beat;

    sixteen_adder u_adder (
        .A    (sum_q),
        .B    (in_data),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    assign count_inc = count_q + 1'b1;
    assign beat      = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    len_d   = len;
                    state_d = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    sum_d   = add_sum;
                    carry_d = carry_q | add_cout;
                    count_d = count_inc;
                    // Count stops at the latched length, so it can never wrap.
                    if (count_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign out_sum     = sum_q;
    assign out_carry   = carry_q;
    assign out_count   = count_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/accum16_seq.md
# accum16_seq

Sequential 16-bit accumulator that sits directly downstream of `sixteen_adder`. It instantiates one `sixteen_adder` with `Cin` tied to 0 as its sole arithmetic datapath. It sums a programmed number of 16-bit samples arriving over a valid/ready stream, records whether any add carried out, and presents the final sum on a held output handshake. It is the first stateful consumer of the adder in the combinational-examples family.

## Interface
- `COUNT_W`, default 8: width of the sample-count register and the `len` input. Maximum length is 2^COUNT_W − 1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begin a new accumulation. Honoured only in IDLE.
- `len`, input, COUNT_W: number of samples to sum. Sampled when `start` is honoured.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: block accepts a sample this cycle.
- `in_data`, input, 16: sample value, unsigned.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `out_valid`, output, 1: result is available.
- `out_ready`, input, 1: downstream consumes the result.
- `out_sum`, output, 16: accumulated sum, modulo 2^16.
- `out_carry`, output, 1: sticky flag; 1 if any add produced `Cout` = 1.
- `out_count`, output, COUNT_W: number of samples accepted so far.

## Operation
- States:
  - IDLE → ACCUM on `start` with `len` ≠ 0.
  - IDLE → DONE on `start` with `len` = 0.
  - ACCUM → DONE when the accepted beat makes count equal to the latched length.
  - DONE → IDLE when `out_valid` && `out_ready`.
- Honouring `start` in IDLE clears sum, carry and count to 0 and latches `len`.
- A beat transfers when `in_valid` && `in_ready`. On a transfer:
  - `{c, s}` = `sixteen_adder(sum, in_data, 0)`.
  - sum ← s.
  - carry ← carry | c.
  - count ← count + 1.
- No transfer means no state change; gaps in `in_valid` are allowed.
- `in_ready` = (state == ACCUM). It is derived from registered state only and has no dependency on `in_valid`.
- `out_valid` = (state == DONE). `out_sum`, `out_carry` and `out_count` are driven directly from registers.
- While in DONE, `out_sum`, `out_carry` and `out_count` stay stable until the handshake completes. After returning to IDLE they keep their values until the next honoured `start`.
- `start` outside IDLE is ignored, with no latch and no effect.
- `start` in the same cycle as the DONE→IDLE handshake is ignored. It must be reissued in IDLE.
- Width rules:
  - Sum wraps modulo 2^16; overflow is reported only through `out_carry`.
  - Count never exceeds the latched length, so it never wraps.
- Reset, in any state including mid-ACCUM or DONE:
  - Next state is IDLE.
  - sum = 0, carry = 0, count = 0, latched length = 0.
  - `in_ready` = 0, `out_valid` = 0, `busy` = 0.
  - Any partial accumulation is discarded.

## Timing
- All outputs are 0 in the cycle after `rst` is sampled high.
- Start latency: `start` honoured at edge t gives `in_ready` = 1 and `busy` = 1 from cycle t+1.
- Throughput: one sample per cycle while in ACCUM.
- Result latency: the last beat accepted at edge k gives `out_valid` = 1 with final values in cycle k+1.
- `len` = 0: `out_valid` = 1 in the cycle after `start`, with sum = 0, carry = 0, count = 0.
- The result handshake at edge m gives `out_valid` = 0 and `busy` = 0 from cycle m+1.
- Combinational path: registered sum → `sixteen_adder` ripple chain → sum register. This must meet one clock period.

## Test plan
- `len`=3, beats 0x0001, 0x0002, 0x0003 back-to-back, `out_ready`=1 → `out_valid` the cycle after the 3rd beat, `out_sum`=0x0006, `out_carry`=0, `out_count`=3, back in IDLE one cycle later.
- `len`=2, beats 0xFFFF, 0x0002 → `out_sum`=0x0001, `out_carry`=1. A following run with `len`=1 and beat 0x0005 → `out_sum`=0x0005, `out_carry`=0, confirming the sticky flag is cleared on start.
- `len`=0, `start` pulse → `out_valid`=1 the next cycle with sum 0, carry 0, count 0, and `in_ready` never asserted.
- `len`=4 with `in_valid` toggling 1,0,0,1,0,1,1 carrying 0x1000 each → `out_sum`=0x4000 one cycle after the 4th transfer. Data presented while `in_valid`=0 does not affect the sum.
- DONE with `out_ready` held 0 for 5 cycles while `start`=1 and `in_valid`=1 → outputs stable, `in_ready`=0, no restart. Raising `out_ready` → IDLE next cycle.
- `rst` asserted after 2 of 5 beats → next cycle all outputs 0 and state IDLE. A new `start` with `len`=1 and beat 0x00AA → `out_sum`=0x00AA, `out_count`=1.
